acq_sequencer: RTL and testbench

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

---
 rtl/acq_sequencer_pkg.sv | 16 +
 rtl/acq_emit_scanner.sv | 51 +++++
 rtl/acq_sequencer.sv | 139 +++++++++++++
 tb/tb_acq_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/acq_sequencer_pkg.sv
// Shared types and constants for the acquisition sequencer.
package acq_sequencer_pkg;

  localparam int unsigned SAMPLE_WORD_W = 16;
  localparam int unsigned BLOCK_LEN     = 16;
  localparam int unsigned BIT_CNT_W     = $clog2(BLOCK_LEN);
  localparam int unsigned DIV_W         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OVF   = 2'd3
  } acq_state_e;

endpackage

// File: rtl/acq_emit_scanner.sv
// Emit buffer for one completed block plus lowest-pending-channel search.
module acq_emit_scanner
  import acq_sequencer_pkg::*;
#(
  parameter int unsigned CHANNELS = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clear,
  input  logic                                    load,
  input  logic [CHANNELS-1:0]                     load_mask,
  input  logic [CHANNELS-1:0][SAMPLE_WORD_W-1:0]  load_data,
  input  logic                                    advance,
  output logic                                    pending_c,
  output logic [SAMPLE_WORD_W-1:0]                word_c
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0][SAMPLE_WORD_W-1:0] words;
  logic [CHANNELS-1:0]                    pend;
  logic [CH_W-1:0]                        sel;

  // Descending scan so the lowest pending channel wins.
  always_comb begin
    sel = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (pend[i]) sel = CH_W'(i);
    end
  end

  assign pending_c = |pend;
  assign word_c    = words[sel];

  // A new block load overrides the pop of the last word of the previous block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words <= '0;
      pend  <= '0;
    end else if (clear) begin
      words <= '0;
      pend  <= '0;
    end else if (load) begin
      words <= load_data;
      pend  <= load_mask;
    end else if (advance) begin
      pend[sel] <= 1'b0;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Multi-channel logic-analyser sequencer: samples probes on a divided tick,
// packs 16 samples per channel and streams enabled channels to a FIFO.
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int unsigned CHANNELS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     acq_enable,
  input  logic [DIV_W-1:0]         clock_divisor,
  input  logic [CHANNELS-1:0]      channel_enable,
  input  logic [CHANNELS-1:0]      probe,
  input  logic                     fifo_full,
  output logic [SAMPLE_WORD_W-1:0] sample_data,
  output logic                     sample_data_avail,
  output logic                     overflow,
  output logic                     running
);

  acq_state_e                              state;
  logic [DIV_W-1:0]                        div_q;
  logic [DIV_W-1:0]                        div_cnt;
  logic [CHANNELS-1:0]                     en_q;
  logic [BIT_CNT_W-1:0]                    bit_cnt;
  logic [CHANNELS-1:0][SAMPLE_WORD_W-1:0]  cap;
  logic [CHANNELS-1:0][SAMPLE_WORD_W-1:0]  blk_c;

  logic                     start_c;
  logic                     tick_c;
  logic                     block_done_c;
  logic                     due_c;
  logic                     advance_c;
  logic                     ovf_c;
  logic                     pending_c;
  logic [SAMPLE_WORD_W-1:0] word_c;

  assign start_c      = (state == IDLE) && acq_enable && (|channel_enable);
  assign tick_c       = (state == RUN) && (div_cnt == '0);
  assign block_done_c = tick_c && (bit_cnt == BIT_CNT_W'(BLOCK_LEN - 1));
  assign due_c        = ((state == RUN) || (state == DRAIN)) && pending_c;
  assign advance_c    = due_c && !fifo_full;
  assign ovf_c        = due_c && fifo_full;

  // Completed block: the sample arriving on the final tick lands in the MSB.
  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      blk_c[c] = {probe[c], cap[c][BLOCK_LEN-2:0]};
    end
  end

  acq_emit_scanner #(
    .CHANNELS (CHANNELS)
  ) u_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_c),
    .load      (block_done_c),
    .load_mask (en_q),
    .load_data (blk_c),
    .advance   (advance_c),
    .pending_c (pending_c),
    .word_c    (word_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      div_q             <= '0;
      div_cnt           <= '0;
      en_q              <= '0;
      bit_cnt           <= '0;
      cap               <= '0;
      sample_data       <= '0;
      sample_data_avail <= 1'b0;
      overflow          <= 1'b0;
      running           <= 1'b0;
    end else begin
      sample_data_avail <= 1'b0;
      if (advance_c) begin
        sample_data       <= word_c;
        sample_data_avail <= 1'b1;
      end

      if (tick_c) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
          cap[c][bit_cnt] <= probe[c];
        end
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end

      if (state == RUN) begin
        div_cnt <= (div_cnt == div_q) ? '0 : div_cnt + DIV_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (start_c) begin
            state    <= RUN;
            running  <= 1'b1;
            div_q    <= clock_divisor;
            en_q     <= channel_enable;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            cap      <= '0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          if (ovf_c) begin
            state    <= OVF;
            overflow <= 1'b1;
            running  <= 1'b0;
          end else if (!acq_enable) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ovf_c) begin
            state    <= OVF;
            overflow <= 1'b1;
            running  <= 1'b0;
          end else if (!pending_c) begin
            state   <= IDLE;
            running <= 1'b0;
          end
        end
        OVF: begin
          if (!acq_enable) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: directed runs push expected words, a monitor checks writes.
module tb_acq_sequencer;

  localparam int unsigned CH = 16;

  logic          clk;
  logic          rst_n;
  logic          acq_enable;
  logic [7:0]    clock_divisor;
  logic [CH-1:0] channel_enable;
  logic [CH-1:0] probe;
  logic          fifo_full;
  logic [15:0]   sample_data;
  logic          sample_data_avail;
  logic          overflow;
  logic          running;

  typedef struct {
    logic [15:0] data;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  acq_sequencer #(.CHANNELS(CH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .acq_enable        (acq_enable),
    .clock_divisor     (clock_divisor),
    .channel_enable    (channel_enable),
    .probe             (probe),
    .fifo_full         (fifo_full),
    .sample_data       (sample_data),
    .sample_data_avail (sample_data_avail),
    .overflow          (overflow),
    .running           (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_word(input logic [15:0] d, input int at);
    exp_t e;
    e.data = d;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Monitor: every FIFO write must match the oldest expected word and its cycle.
  always @(negedge clk) begin
    if (sample_data_avail) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got data %h at cycle %0d, expected no write", sample_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("write_data", 32'(sample_data), 32'(e.data));
        check("write_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_run(input logic [7:0] d, input logic [CH-1:0] en, output int t0);
    clock_divisor  = d;
    channel_enable = en;
    acq_enable     = 1'b1;
    @(negedge clk);
    t0 = cyc;
  endtask

  task automatic go_idle();
    acq_enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int          t0;
    logic [15:0] p;

    rst_n          = 1'b0;
    acq_enable     = 1'b0;
    clock_divisor  = 8'd0;
    channel_enable = '0;
    probe          = '0;
    fifo_full      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(sample_data), 32'h0);
    check("rst_avail", 32'(sample_data_avail), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ch0 toggling from 0, divisor 0: 16'hAAAA every 16 cycles from cycle 17.
    start_run(8'd0, 16'h0001, t0);
    expect_word(16'hAAAA, t0 + 17);
    expect_word(16'hAAAA, t0 + 33);
    expect_word(16'hAAAA, t0 + 49);
    for (int k = 1; k <= 50; k++) begin
      probe[0] = ~k[0];
      if (k == 50) acq_enable = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("s1_running_after_drain", 32'(running), 32'h0);
    probe = '0;

    // divisor 3, ch0+ch15; later config changes must be ignored.
    probe = 16'h8000;
    start_run(8'd3, 16'h8001, t0);
    clock_divisor  = 8'd0;
    channel_enable = 16'hFFFF;
    expect_word(16'h0000, t0 + 62);
    expect_word(16'hFFFF, t0 + 63);
    expect_word(16'h0000, t0 + 126);
    expect_word(16'hFFFF, t0 + 127);
    wait_until(t0 + 129);
    go_idle();
    check("s2_running_idle", 32'(running), 32'h0);

    // Overflow on the 5th word of a full-width block.
    probe = 16'h000A;
    start_run(8'd0, 16'hFFFF, t0);
    expect_word(16'h0000, t0 + 17);
    expect_word(16'hFFFF, t0 + 18);
    expect_word(16'h0000, t0 + 19);
    expect_word(16'hFFFF, t0 + 20);
    wait_until(t0 + 20);
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_running", 32'(running), 32'h0);
    check("ovf_avail", 32'(sample_data_avail), 32'h0);
    repeat (40) @(negedge clk);
    check("ovf_held_in_ovf", 32'(overflow), 32'h1);
    go_idle();
    check("ovf_held_in_idle", 32'(overflow), 32'h1);
    start_run(8'd0, 16'hFFFF, t0);
    check("ovf_cleared_on_rerun", 32'(overflow), 32'h0);
    check("rerun_running", 32'(running), 32'h1);
    go_idle();
    check("rerun_short_drain", 32'(running), 32'h0);

    // Stop after 20 ticks: exactly one block, running drops one cycle after last write.
    p     = 16'h5A0F;
    probe = p;
    start_run(8'd0, 16'hFFFF, t0);
    for (int c = 0; c < 16; c++) expect_word(p[c] ? 16'hFFFF : 16'h0000, t0 + 17 + c);
    wait_until(t0 + 20);
    acq_enable = 1'b0;
    wait_until(t0 + 32);
    check("s4_running_at_last_write", 32'(running), 32'h1);
    @(negedge clk);
    check("s4_running_after_last", 32'(running), 32'h0);
    repeat (20) @(negedge clk);

    // Stop coincides with the final tick of a block: block still emitted in DRAIN.
    probe = 16'h0001;
    start_run(8'd0, 16'h0001, t0);
    expect_word(16'hFFFF, t0 + 17);
    wait_until(t0 + 15);
    acq_enable = 1'b0;
    wait_until(t0 + 17);
    check("s5_running_drain", 32'(running), 32'h1);
    @(negedge clk);
    check("s5_running_idle", 32'(running), 32'h0);
    repeat (20) @(negedge clk);

    // No enabled channel keeps the sequencer idle.
    acq_enable     = 1'b1;
    channel_enable = '0;
    repeat (6) @(negedge clk);
    check("no_channels_idle", 32'(running), 32'h0);
    go_idle();

    // Asynchronous reset during emission.
    probe = 16'h00FF;
    start_run(8'd0, 16'hFFFF, t0);
    expect_word(16'hFFFF, t0 + 17);
    expect_word(16'hFFFF, t0 + 18);
    expect_word(16'hFFFF, t0 + 19);
    wait_until(t0 + 19);
    #2 rst_n = 1'b0;
    #1;
    check("arst_avail", 32'(sample_data_avail), 32'h0);
    check("arst_data", 32'(sample_data), 32'h0);
    check("arst_running", 32'(running), 32'h0);
    check("arst_overflow", 32'(overflow), 32'h0);
    acq_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_idle", 32'(running), 32'h0);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
